// File: rtl/imem_prog.sv
// Field-programmable instruction memory: registered fetch port with fault
// reporting, plus a byte-serial load port that assembles and writes 32-bit words.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  S_RUN  | fetch port live; programming bytes refused
//  S_LOAD | bytes accepted and assembled into words; fetches ignored
//  S_DONE | one-cycle end-of-load pulse, then back to S_RUN
module imem_prog #(
    parameter int ADDR_WIDTH = 10,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [31:0]           i_iaddr,
    input  logic                  i_ireq,
    output logic [31:0]           o_idata,
    output logic                  o_ivalid,
    output logic                  o_ifault,
    input  logic                  i_prog_en,
    input  logic [7:0]            i_prog_byte,
    input  logic                  i_prog_valid,
    output logic                  o_prog_ready,
    output logic                  o_prog_done,
    output logic [ADDR_WIDTH-2:0] o_prog_count,
    output logic                  o_busy
);

    localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
    localparam int PW    = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {S_RUN, S_LOAD, S_DONE} state_t;

    state_t                r_state;
    logic [31:0]           r_mem [WORDS];
    logic [PW-1:0]         r_wptr;
    logic [1:0]            r_bidx;
    logic [23:0]           r_asm;
    logic [ADDR_WIDTH-2:0] r_count;
    logic [31:0]           r_idata;
    logic                  r_ivalid;
    logic                  r_ifault;
    logic                  r_prog_ready;
    logic                  r_prog_done;
    logic                  r_busy;
    logic                  r_armed;

    logic                  w_accept;
    logic                  w_word_done;
    logic                  w_full;
    logic [31:0]           w_word;
    logic                  w_fault;
    logic [PW-1:0]         w_ridx;

    assign w_accept    = (r_state == S_LOAD) & r_prog_ready & i_prog_valid;
    assign w_word_done = w_accept & (r_bidx == 2'd3);
    assign w_full      = w_word_done & (r_wptr == {PW{1'b1}});
    assign w_word      = BIG_ENDIAN ? {r_asm, i_prog_byte} : {i_prog_byte, r_asm};
    assign w_fault     = (i_iaddr[1:0] != 2'b00) | (i_iaddr[31:ADDR_WIDTH] != '0);
    assign w_ridx      = i_iaddr[ADDR_WIDTH-1:2];

    // Contents deliberately outlive reset so a loaded program stays resident.
    always_ff @(posedge i_clk) begin
        if (w_word_done) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_RUN;
            r_wptr       <= '0;
            r_bidx       <= '0;
            r_asm        <= '0;
            r_count      <= '0;
            r_idata      <= '0;
            r_ivalid     <= 1'b0;
            r_ifault     <= 1'b0;
            r_prog_ready <= 1'b0;
            r_prog_done  <= 1'b0;
            r_busy       <= 1'b0;
            r_armed      <= 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (i_prog_en && r_armed) begin
                        r_state      <= S_LOAD;
                        r_wptr       <= '0;
                        r_bidx       <= '0;
                        r_count      <= '0;
                        r_ivalid     <= 1'b0;
                        r_prog_ready <= 1'b1;
                        r_busy       <= 1'b1;
                    end else begin
                        r_ivalid <= i_ireq;
                        if (i_ireq) begin
                            r_ifault <= w_fault;
                            r_idata  <= w_fault ? 32'h0000_0000 : r_mem[w_ridx];
                        end
                        if (!i_prog_en) begin
                            r_armed <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_ivalid <= 1'b0;
                    if (w_accept) begin
                        r_asm  <= BIG_ENDIAN ? {r_asm[15:0], i_prog_byte}
                                             : {i_prog_byte, r_asm[23:8]};
                        r_bidx <= r_bidx + 2'd1;
                    end
                    if (w_word_done) begin
                        r_count <= r_count + 1'b1;
                        if (!w_full) begin
                            r_wptr <= r_wptr + 1'b1;
                        end
                    end
                    // A partial word left in r_asm is simply dropped here.
                    if (!i_prog_en || w_full) begin
                        r_state      <= S_DONE;
                        r_prog_ready <= 1'b0;
                        r_prog_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state     <= S_RUN;
                    r_ivalid    <= 1'b0;
                    r_prog_done <= 1'b0;
                    r_busy      <= 1'b0;
                    r_armed     <= !i_prog_en;
                end
                default: begin
                    r_state      <= S_RUN;
                    r_ivalid     <= 1'b0;
                    r_prog_ready <= 1'b0;
                    r_prog_done  <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign o_idata      = r_idata;
    assign o_ivalid     = r_ivalid;
    assign o_ifault     = r_ifault;
    assign o_prog_ready = r_prog_ready;
    assign o_prog_done  = r_prog_done;
    assign o_prog_count = r_count;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_imem_prog.sv
// Bench for imem_prog: big- and little-endian instances share one stimulus
// stream; fetch results are checked against a model memory via queues.
module tb_imem_prog;

    localparam int AW = 10;

    logic        clk;
    logic        rst_n;
    logic [31:0] iaddr;
    logic        ireq;
    logic        prog_en;
    logic [7:0]  prog_byte;
    logic        prog_valid;

    logic [31:0]   idata_be, idata_le;
    logic          ivalid_be, ivalid_le, ifault_be, ifault_le;
    logic          ready_be, ready_le, done_be, done_le, busy_be, busy_le;
    logic [AW-2:0] count_be, count_le;

    int n_cmp = 0;
    int n_err = 0;

    logic [32:0] q_be[$];
    logic [32:0] q_le[$];

    logic [31:0] m_be [0:255];
    logic [31:0] m_le [0:255];
    logic [7:0]  m_b  [0:3];
    int          m_ptr, m_idx, m_cnt;

    imem_prog #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b1)) u_be (
        .i_clk(clk), .i_rst_n(rst_n), .i_iaddr(iaddr), .i_ireq(ireq),
        .o_idata(idata_be), .o_ivalid(ivalid_be), .o_ifault(ifault_be),
        .i_prog_en(prog_en), .i_prog_byte(prog_byte), .i_prog_valid(prog_valid),
        .o_prog_ready(ready_be), .o_prog_done(done_be), .o_prog_count(count_be),
        .o_busy(busy_be));

    imem_prog #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b0)) u_le (
        .i_clk(clk), .i_rst_n(rst_n), .i_iaddr(iaddr), .i_ireq(ireq),
        .o_idata(idata_le), .o_ivalid(ivalid_le), .o_ifault(ifault_le),
        .i_prog_en(prog_en), .i_prog_byte(prog_byte), .i_prog_valid(prog_valid),
        .o_prog_ready(ready_le), .o_prog_done(done_le), .o_prog_count(count_le),
        .o_busy(busy_le));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] expect_of(input logic [31:0] a, input bit le);
        logic f;
        f = (a[1:0] != 2'b00) || (a[31:AW] != '0);
        if (f) return {1'b1, 32'h0};
        return {1'b0, le ? m_le[a[AW-1:2]] : m_be[a[AW-1:2]]};
    endfunction

    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n && ivalid_be) begin
            chk("sb_be_pending", 64'(q_be.size() != 0), 64'd1);
            if (q_be.size() != 0) begin
                e = q_be.pop_front();
                chk("fetch_be", {31'd0, ifault_be, idata_be}, {31'd0, e});
            end
        end
        if (rst_n && ivalid_le) begin
            chk("sb_le_pending", 64'(q_le.size() != 0), 64'd1);
            if (q_le.size() != 0) begin
                e = q_le.pop_front();
                chk("fetch_le", {31'd0, ifault_le, idata_le}, {31'd0, e});
            end
        end
    end

    task automatic issue(input logic [31:0] a);
        ireq  = 1'b1;
        iaddr = a;
        q_be.push_back(expect_of(a, 1'b0));
        q_le.push_back(expect_of(a, 1'b1));
        tick();
        chk("ivalid_be", 64'(ivalid_be), 64'd1);
        chk("ivalid_le", 64'(ivalid_le), 64'd1);
    endtask

    task automatic idle();
        ireq = 1'b0;
        tick();
        chk("ivalid_idle", 64'(ivalid_be | ivalid_le), 64'd0);
    endtask

    task automatic begin_load();
        prog_en = 1'b1;
        tick();
        chk("load_busy", 64'(busy_be & busy_le), 64'd1);
        chk("load_ready", 64'(ready_be & ready_le), 64'd1);
        m_ptr = 0;
        m_idx = 0;
        m_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        chk("ready_before_byte", 64'(ready_be & ready_le), 64'd1);
        prog_valid = 1'b1;
        prog_byte  = b;
        tick();
        m_b[m_idx] = b;
        m_idx++;
        if (m_idx == 4) begin
            m_be[m_ptr] = {m_b[0], m_b[1], m_b[2], m_b[3]};
            m_le[m_ptr] = {m_b[3], m_b[2], m_b[1], m_b[0]};
            m_ptr++;
            m_cnt++;
            m_idx = 0;
        end
    endtask

    task automatic end_load();
        prog_valid = 1'b0;
        prog_en    = 1'b0;
        tick();
        chk("done_pulse", 64'(done_be & done_le), 64'd1);
        chk("done_ready_low", 64'(ready_be | ready_le), 64'd0);
        tick();
        chk("done_cleared", 64'(done_be | done_le), 64'd0);
        chk("busy_after_done", 64'(busy_be | busy_le), 64'd0);
        chk("count_be", 64'(count_be), 64'(m_cnt));
        chk("count_le", 64'(count_le), 64'(m_cnt));
    endtask

    initial begin
        rst_n = 1'b0; iaddr = '0; ireq = 1'b0;
        prog_en = 1'b0; prog_byte = '0; prog_valid = 1'b0;
        m_ptr = 0; m_idx = 0; m_cnt = 0;
        tick(); tick();
        chk("rst_idata", 64'(idata_be | idata_le), 64'd0);
        chk("rst_ivalid", 64'(ivalid_be | ivalid_le), 64'd0);
        chk("rst_ifault", 64'(ifault_be | ifault_le), 64'd0);
        chk("rst_ready", 64'(ready_be | ready_le), 64'd0);
        chk("rst_done", 64'(done_be | done_le), 64'd0);
        chk("rst_count", 64'(count_be | count_le), 64'd0);
        chk("rst_busy", 64'(busy_be | busy_le), 64'd0);
        rst_n = 1'b1;
        tick();

        // two-word load, then back-to-back fetch
        begin_load();
        send_byte(8'h3c); send_byte(8'h01); send_byte(8'h10); send_byte(8'h01);
        send_byte(8'h34); send_byte(8'h3d); send_byte(8'h00); send_byte(8'h04);
        end_load();
        chk("model_word0", 64'(m_be[0]), 64'h3c011001);
        issue(32'h0); issue(32'h4); idle();
        chk("count_holds", 64'(count_be), 64'd2);

        // faulting fetches
        issue(32'h2); issue(32'h400); issue(32'hffff_fffc); issue(32'h1); idle();

        // partial word is discarded
        begin_load();
        send_byte(8'haa); send_byte(8'hbb); send_byte(8'hcc);
        end_load();
        issue(32'h0); idle();

        // byte order: LE instance sees 0x3c011001
        begin_load();
        send_byte(8'h01); send_byte(8'h10); send_byte(8'h01); send_byte(8'h3c);
        end_load();
        chk("model_le_word0", 64'(m_le[0]), 64'h3c011001);
        issue(32'h0); idle();

        // prog_en beats simultaneous ireq, then reset mid-load
        prog_en = 1'b1; ireq = 1'b1; iaddr = 32'h4;
        tick();
        chk("race_no_ivalid", 64'(ivalid_be | ivalid_le), 64'd0);
        chk("race_busy", 64'(busy_be & busy_le), 64'd1);
        chk("race_ready", 64'(ready_be & ready_le), 64'd1);
        ireq = 1'b0;
        m_ptr = 0; m_idx = 0; m_cnt = 0;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55);
        rst_n = 1'b0; prog_en = 1'b0; prog_valid = 1'b0;
        #1;
        chk("rst_mid_ready", 64'(ready_be | ready_le), 64'd0);
        chk("rst_mid_busy", 64'(busy_be | busy_le), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_mid_count", 64'(count_be | count_le), 64'd0);
        issue(32'h0); issue(32'h4); idle();

        // fill the whole memory
        begin_load();
        for (int i = 0; i < 1024; i++) begin
            send_byte(8'(i ^ (i >> 3)));
        end
        chk("full_done", 64'(done_be & done_le), 64'd1);
        chk("full_ready_low", 64'(ready_be | ready_le), 64'd0);
        chk("full_count_be", 64'(count_be), 64'd256);
        chk("full_count_le", 64'(count_le), 64'd256);
        prog_byte = 8'hee;
        tick();
        chk("full_done_clear", 64'(done_be | done_le), 64'd0);
        chk("full_busy_low", 64'(busy_be | busy_le), 64'd0);
        chk("full_no_extra", 64'(count_be), 64'd256);
        tick();
        chk("no_reentry_busy", 64'(busy_be | busy_le), 64'd0);
        chk("no_reentry_ready", 64'(ready_be | ready_le), 64'd0);
        prog_en = 1'b0; prog_valid = 1'b0;
        tick();
        issue(32'h0); issue(32'h3fc); issue(32'h200); idle();
        idle();

        chk("sb_be_drained", 64'(q_be.size()), 64'd0);
        chk("sb_le_drained", 64'(q_le.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_prog.md
# imem_prog

Parametrised, field-programmable instruction memory for the pipelined CPU's fetch stage. It replaces a fixed, combinationally read instruction ROM with a registered-read fetch port that reports faults, plus a byte-serial programming port. A load FSM assembles incoming bytes into 32-bit instruction words and writes them while the fetch port is held off. Memory contents survive reset, so a program loaded once stays resident across CPU resets.

## Interface
- ADDR_WIDTH, 10: byte-address bits decoded; depth WORDS = 2**(ADDR_WIDTH-2) words of 32 bits.
- BIG_ENDIAN, 1: 1 = first programming byte lands in [31:24]; 0 = first byte lands in [7:0].
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- iaddr  in  32  fetch byte address.
- ireq  in  1  fetch request, sampled at clock edge.
- idata  out  32  registered instruction word.
- ivalid  out  1  idata/ifault valid this cycle.
- ifault  out  1  fetch was misaligned or out of range.
- prog_en  in  1  level; high requests/holds load mode.
- prog_byte  in  8  programming data byte.
- prog_valid  in  1  prog_byte valid.
- prog_ready  out  1  block accepts a byte this cycle.
- prog_done  out  1  one-cycle pulse at end of load.
- prog_count  out  ADDR_WIDTH-1  complete words written in current/last load.
- busy  out  1  high in LOAD and DONE.

## Operation
- States RUN, LOAD, DONE. Reset state RUN.
- RUN:
  - Sampled ireq=1 produces ivalid=1 on the next cycle.
  - ifault = (iaddr[1:0]!=0) | (iaddr[31:ADDR_WIDTH]!=0).
  - idata = mem[iaddr[ADDR_WIDTH-1:2]], or 32'h00000000 (nop) on fault.
  - prog_ready=0.
- RUN -> LOAD when prog_en=1 is sampled.
  - prog_en wins over a simultaneous ireq: that request is dropped and no ivalid follows.
  - Entering LOAD clears the word pointer, byte index (0..3) and prog_count.
- LOAD:
  - prog_ready=1.
  - Each cycle with prog_valid&prog_ready accepts one byte into the assembly register, placed per BIG_ENDIAN.
  - On the 4th byte, the word is written to mem[wptr] on that same edge; wptr and prog_count increment.
  - ireq is ignored; ivalid=0.
- LOAD -> DONE:
  - When prog_en is sampled low. A partial word (byte index != 0) is discarded and never written.
  - Or automatically on the edge that writes word WORDS-1 (memory full). In this case prog_count=WORDS and no wrap occurs; further bytes are refused.
- DONE: lasts one cycle with prog_done=1 and prog_ready=0, then returns to RUN. If prog_en is still high, it must drop before a new LOAD can start: re-entry from RUN needs prog_en sampled low at least once after DONE.
- prog_count holds its value in RUN until the next LOAD entry.

## Timing
- Reset values: idata=0, ivalid=0, ifault=0, prog_ready=0, prog_done=0, prog_count=0, busy=0, state RUN.
- Memory array is not reset.
- Reset asserted mid-load immediately forces RUN and discards the assembly register. Words already written are retained.
- Fetch latency is 1 cycle, throughput 1 per cycle; back-to-back ireq yields back-to-back ivalid.
- A word written in LOAD is readable by the first fetch issued in RUN after DONE.
- prog_ready rises the cycle after prog_en is sampled high. It falls in the cycle after prog_en is sampled low or the last word is written.

## Test plan
- Load bytes 3c 01 10 01 34 3d 00 04, then drop prog_en: prog_done pulses once, prog_count=2. Fetch 0x0 then 0x4 back-to-back: ivalid on consecutive cycles with idata 0x3c011001 then 0x343d0004, ifault=0.
- BIG_ENDIAN=0, bytes 01 10 01 3c: fetch 0x0 returns 0x3c011001.
- Fetch 0x2 -> ifault=1, idata=0. Fetch 0x400 (ADDR_WIDTH=10) -> ifault=1, idata=0.
- Load 3 bytes, then drop prog_en: prog_count=0 and word 0 unchanged. Separately, load 1024 bytes: automatic DONE after byte 1024 with prog_count=256, and prog_ready=0 for the 1025th byte.
- Assert rst after 5 bytes accepted: prog_ready=0 and busy=0 at once. After release, fetch 0x0 returns the first word and fetch 0x4 returns its old contents.
- prog_en and ireq high in the same cycle: no ivalid next cycle, busy=1, prog_ready=1.
